// File: rtl/weight_feeder.sv
// Loads one 3x3 kernel (four output channels) from the weight buffer into computing_core,
// checking the core's weight_load_done handshake on every strobe beat.
module weight_feeder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TAPS   = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                weights_valid,
  output logic                mem_ren,
  output logic [ADDR_W-1:0]   mem_raddr,
  input  logic [4*WIDTH-1:0]  mem_rdata,
  output logic                weight_load,
  output logic [WIDTH-1:0]    weight0,
  output logic [WIDTH-1:0]    weight1,
  output logic [WIDTH-1:0]    weight2,
  output logic [WIDTH-1:0]    weight3,
  input  logic                weight_load_done
);

  localparam logic [3:0] LastTap = 4'(TAPS - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFinish} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic              ren_q;
  logic              wload_q;
  logic [WIDTH-1:0]  w0_q, w1_q, w2_q, w3_q;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              accept;
  logic              last_beat;

  assign last_beat = (beat_cnt_q == LastTap);

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    base_d   = base_q;
    accept   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept   = 1'b1;
          base_d   = base_addr;
          rd_cnt_d = 4'd0;
          state_d  = StRead;
        end
      end
      StRead: begin
        if (rd_cnt_q == LastTap) begin
          rd_cnt_d = 4'd0;
          state_d  = StDrain;
        end else begin
          rd_cnt_d = rd_cnt_q + 4'd1;
        end
      end
      StDrain: begin
        // Leave only once the final strobe beat is on the core interface.
        if (wload_q && last_beat) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    valid_d    = valid_q;
    if (accept) begin
      beat_cnt_d = 4'd0;
      err_d      = 1'b0;
      valid_d    = 1'b0;
    end else begin
      if (wload_q) begin
        beat_cnt_d = beat_cnt_q + 4'd1;
        // Core must flag done on the last beat and only there.
        if (weight_load_done != last_beat) err_d = 1'b1;
      end
      if (state_q == StFinish) valid_d = ~err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      ren_q      <= 1'b0;
      wload_q    <= 1'b0;
      w0_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      w3_q       <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      ren_q      <= mem_ren;
      wload_q    <= ren_q;
      if (ren_q) begin
        w0_q <= mem_rdata[WIDTH-1:0];
        w1_q <= mem_rdata[2*WIDTH-1:WIDTH];
        w2_q <= mem_rdata[3*WIDTH-1:2*WIDTH];
        w3_q <= mem_rdata[4*WIDTH-1:3*WIDTH];
      end
    end
  end

  always_comb begin
    busy          = (state_q != StIdle);
    mem_ren       = (state_q == StRead);
    mem_raddr     = mem_ren ? (base_q + ADDR_W'(rd_cnt_q)) : '0;
    done          = (state_q == StFinish);
    err           = done & err_q;
    weights_valid = valid_q;
    weight_load   = wload_q;
    weight0       = w0_q;
    weight1       = w1_q;
    weight2       = w2_q;
    weight3       = w3_q;
  end

endmodule

// File: tb/tb_weight_feeder.sv
// Directed bench for weight_feeder with a behavioural weight buffer and core weight path.
module tb_weight_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic        busy, done, err, weights_valid;
  logic        mem_ren;
  logic [9:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        weight_load;
  logic [7:0]  weight0, weight1, weight2, weight3;
  logic        weight_load_done;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] mem [1024];
  logic [7:0]  core_slot [9][4];
  int          core_idx;
  logic        preset_req;
  int          preset_val;
  logic [9:0]  seen_addr [9];

  weight_feeder #(.WIDTH(8), .ADDR_W(10), .TAPS(9)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .base_addr        (base_addr),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .weights_valid    (weights_valid),
    .mem_ren          (mem_ren),
    .mem_raddr        (mem_raddr),
    .mem_rdata        (mem_rdata),
    .weight_load      (weight_load),
    .weight0          (weight0),
    .weight1          (weight1),
    .weight2          (weight2),
    .weight3          (weight3),
    .weight_load_done (weight_load_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  // Core weight path: slot index advances per strobe and wraps after slot 8.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_idx <= 0;
    end else if (preset_req) begin
      core_idx <= preset_val;
    end else if (weight_load) begin
      core_slot[core_idx][0] <= weight0;
      core_slot[core_idx][1] <= weight1;
      core_slot[core_idx][2] <= weight2;
      core_slot[core_idx][3] <= weight3;
      core_idx <= (core_idx == 8) ? 0 : core_idx + 1;
    end
  end

  assign weight_load_done = weight_load && (core_idx == 8);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preset_core(input int val);
    preset_val = val;
    preset_req = 1'b1;
    step();
    preset_req = 1'b0;
  endtask

  // One complete load from cycle S (now) to S+13, checked every cycle.
  task automatic run_load(input logic [9:0] base, input bit exp_err, input int done_beat,
                          input bit prev_valid, input string tag);
    logic [9:0]  a;
    logic [31:0] w;
    bit          e_busy, e_ren, e_wl, e_done, e_valid;
    vectors++;
    if (weights_valid !== prev_valid) begin
      errors++;
      $display("FAIL %s pre-start weights_valid: got %b want %b", tag, weights_valid, prev_valid);
    end
    start     = 1'b1;
    base_addr = base;
    for (int c = 1; c <= 13; c++) begin
      step();
      start   = 1'b0;
      e_busy  = (c >= 1 && c <= 12);
      e_ren   = (c >= 1 && c <= 9);
      e_wl    = (c >= 3 && c <= 11);
      e_done  = (c == 12);
      e_valid = (c == 13) ? !exp_err : 1'b0;
      vectors += 5;
      if (busy !== e_busy) begin
        errors++; $display("FAIL %s c%0d busy: got %b want %b", tag, c, busy, e_busy);
      end
      if (mem_ren !== e_ren) begin
        errors++; $display("FAIL %s c%0d mem_ren: got %b want %b", tag, c, mem_ren, e_ren);
      end
      if (weight_load !== e_wl) begin
        errors++; $display("FAIL %s c%0d weight_load: got %b want %b", tag, c, weight_load, e_wl);
      end
      if (done !== e_done || err !== (e_done && exp_err)) begin
        errors++;
        $display("FAIL %s c%0d done/err: got %b/%b want %b/%b", tag, c, done, err, e_done,
                 e_done && exp_err);
      end
      if (weights_valid !== e_valid) begin
        errors++;
        $display("FAIL %s c%0d weights_valid: got %b want %b", tag, c, weights_valid, e_valid);
      end
      vectors++;
      if (weight_load_done !== (c == done_beat + 2)) begin
        errors++;
        $display("FAIL %s c%0d weight_load_done: got %b want %b", tag, c, weight_load_done,
                 c == done_beat + 2);
      end
      if (e_ren) begin
        a = base + 10'(c - 1);
        seen_addr[c-1] = mem_raddr;
        vectors++;
        if (mem_raddr !== a) begin
          errors++; $display("FAIL %s c%0d mem_raddr: got %0d want %0d", tag, c, mem_raddr, a);
        end
      end
      if (c >= 3) begin
        // Outputs hold the last tap once the strobe drops.
        a = base + 10'((c > 11 ? 11 : c) - 3);
        w = mem[a];
        vectors++;
        if ({weight3, weight2, weight1, weight0} !== w) begin
          errors++;
          $display("FAIL %s c%0d weights: got %h want %h", tag, c,
                   {weight3, weight2, weight1, weight0}, w);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    vectors += 3;
    if ({busy, done, err, weights_valid} !== 4'b0) begin
      errors++; $display("FAIL reset status: got %b want 0000", {busy, done, err, weights_valid});
    end
    if ({mem_ren, mem_raddr} !== 11'b0) begin
      errors++; $display("FAIL reset mem: got %b/%0d want 0/0", mem_ren, mem_raddr);
    end
    if ({weight_load, weight3, weight2, weight1, weight0} !== 33'b0) begin
      errors++; $display("FAIL reset weights: got %b/%h want 0/0", weight_load,
                         {weight3, weight2, weight1, weight0});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] want;
    run_load(10'd16, 1'b0, 9, 1'b0, "basic");
    for (int k = 0; k < 9; k++) begin
      for (int ch = 0; ch < 4; ch++) begin
        want = 8'(k + 16 * ch);
        vectors++;
        if (core_slot[k][ch] !== want) begin
          errors++;
          $display("FAIL core_slot[%0d][%0d]: got %0d want %0d", k, ch, core_slot[k][ch], want);
        end
      end
    end
    step();
  endtask

  task automatic test_start_held();
    bit e_busy, e_ren, e_done, e_valid;
    int dones = 0;
    start     = 1'b1;
    base_addr = 10'd16;
    for (int c = 1; c <= 26; c++) begin
      step();
      if (c == 26) start = 1'b0;
      e_busy  = (c <= 12) || (c >= 14 && c <= 25);
      e_ren   = (c <= 9) || (c >= 14 && c <= 22);
      e_done  = (c == 12) || (c == 25);
      e_valid = (c == 13) || (c == 26);
      if (done) dones++;
      vectors += 4;
      if (busy !== e_busy) begin
        errors++; $display("FAIL held c%0d busy: got %b want %b", c, busy, e_busy);
      end
      if (mem_ren !== e_ren) begin
        errors++; $display("FAIL held c%0d mem_ren: got %b want %b", c, mem_ren, e_ren);
      end
      if (done !== e_done || err !== 1'b0) begin
        errors++; $display("FAIL held c%0d done/err: got %b/%b want %b/0", c, done, err, e_done);
      end
      if (weights_valid !== e_valid) begin
        errors++;
        $display("FAIL held c%0d weights_valid: got %b want %b", c, weights_valid, e_valid);
      end
    end
    vectors++;
    if (dones != 2) begin
      errors++; $display("FAIL held done count: got %0d want 2", dones);
    end
    step();
  endtask

  task automatic test_misaligned();
    preset_core(3);
    run_load(10'd16, 1'b1, 6, 1'b1, "misaligned");
    step();
    vectors++;
    if (weights_valid !== 1'b0) begin
      errors++; $display("FAIL misaligned stays invalid: got %b want 0", weights_valid);
    end
    preset_core(0);
    run_load(10'd16, 1'b0, 9, 1'b0, "aligned");
    step();
  endtask

  task automatic test_wrap();
    logic [9:0] want [9];
    want = '{10'd1020, 10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2, 10'd3, 10'd4};
    run_load(10'd1020, 1'b0, 9, 1'b1, "wrap");
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (seen_addr[k] !== want[k]) begin
        errors++; $display("FAIL wrap addr %0d: got %0d want %0d", k, seen_addr[k], want[k]);
      end
    end
    step();
  endtask

  task automatic test_async_reset();
    int dones = 0;
    start     = 1'b1;
    base_addr = 10'd16;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
      if (done) dones++;
    end
    vectors++;
    if (weight_load !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL areset pre: got wl=%b busy=%b want 1/1", weight_load, busy);
    end
    rst_n = 1'b0;
    #1;
    vectors += 2;
    if ({weight_load, busy, mem_ren} !== 3'b0) begin
      errors++; $display("FAIL areset async drop: got %b want 000", {weight_load, busy, mem_ren});
    end
    if (weights_valid !== 1'b0) begin
      errors++; $display("FAIL areset weights_valid: got %b want 0", weights_valid);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (done) dones++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done) dones++;
    end
    vectors++;
    if (dones != 0) begin
      errors++; $display("FAIL areset done pulses: got %0d want 0", dones);
    end
    run_load(10'd16, 1'b0, 9, 1'b0, "post-reset");
    step();
  endtask

  initial begin
    start      = 1'b0;
    base_addr  = '0;
    preset_req = 1'b0;
    preset_val = 0;
    rst_n      = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = {8'(a * 3 + 5), 8'(a + 77), 8'(a ^ 8'h5a), 8'(a)};
    for (int k = 0; k < 9; k++) mem[16+k] = {8'(k + 48), 8'(k + 32), 8'(k + 16), 8'(k)};
    test_reset();
    test_basic();
    test_start_held();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/weight_feeder.md
Name: weight_feeder

Overview:
- Loads one 3x3 kernel set for four output channels into computing_core's weight registers.
- Reads nine packed weight words from a synchronous weight buffer and drives computing_core's weight_load, weight0..weight3 strobe sequence.
- Checks the core's weight_load_done handshake and tells the layer controller when activation streaming may begin.

Parameters:
WIDTH, 8, bit width of one weight (matches computing_core WIDTH)
ADDR_W, 10, weight buffer address width
TAPS, 9, kernel taps per load (fixed 3x3; not meant to be overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request one kernel load; sampled only in IDLE
base_addr  in  ADDR_W  buffer address of tap 0; captured when start is accepted
busy  out  1  high while a load is in progress
done  out  1  one-cycle pulse when a load finishes (success or error)
err  out  1  one-cycle pulse coincident with done when the handshake check failed
weights_valid  out  1  level; core holds a complete, verified kernel set
mem_ren  out  1  weight buffer read enable
mem_raddr  out  ADDR_W  weight buffer read address
mem_rdata  in  4*WIDTH  read data, valid exactly 1 cycle after mem_ren; packed {w3,w2,w1,w0}
weight_load  out  1  to computing_core weight_load
weight0  out  WIDTH  to computing_core weight0 (= mem_rdata[WIDTH-1:0])
weight1  out  WIDTH  to computing_core weight1
weight2  out  WIDTH  to computing_core weight2
weight3  out  WIDTH  to computing_core weight3 (= mem_rdata[4*WIDTH-1:3*WIDTH])
weight_load_done  in  1  from computing_core; high when the core is writing its last tap slot

Behaviour:
- Reset (rst_n low, async): all outputs are 0, FSM is in IDLE, all counters are 0.
- The core's tap index is not cleared by this block. The system resets both blocks together.
- Buffer layout: word base_addr+k holds tap k for all four channels, k=0..8. Tap k lands in core slot k.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).
- FSM states: IDLE, READ, DRAIN, FINISH.
- IDLE -> READ: start sampled high at cycle S. Capture base_addr, clear weights_valid, set busy from S+1.
- READ, cycles S+1..S+9:
  - mem_ren=1, mem_raddr=base+rd_cnt, rd_cnt counting 0..8.
  - Move to DRAIN after rd_cnt=8.
- Read pipeline:
  - Data returns at S+2..S+10.
  - It is registered into the weight0..3 outputs, with weight_load registered alongside.
  - weight_load is therefore high for exactly 9 consecutive cycles, S+3..S+11.
  - weight0..3 hold their last value when weight_load=0.
- DRAIN: wait until the 9th weight_load beat (S+11) has been issued, then go to FINISH.
- Handshake check, sampled on each beat:
  - weight_load_done must be 0 on beats 1..8 and 1 on beat 9.
  - Any violation sets an internal sticky error flag.
- FINISH, cycle S+12:
  - done=1 and busy=1.
  - err=1 if the error flag is set.
  - weights_valid set to 1 at S+13 only if there was no error.
  - Return to IDLE at S+13, busy=0.
- Total latency: start to done is 12 cycles. The earliest next accepted start is S+13.
- start while busy (including the FINISH cycle): ignored, with no queuing.
- weights_valid stays high until the next accepted start or reset.
- Reset mid-load: everything aborts immediately. weight_load drops asynchronously and weights_valid=0.

Test Plan:
- Basic load: buffer[16+k] = {k+48, k+32, k+16, k}, start with base_addr=16 at cycle S. Required response:
  - mem_raddr 16..24 on S+1..S+9.
  - weight_load high S+3..S+11; weight0 = 0..8 and weight3 = 48..56 in order.
  - done at S+12 with err=0; weights_valid=1 from S+13.
- Core model: a behavioural computing_core weight path. After the basic load, its slot k must equal tap k for all four channels, and weight_load_done must be seen exactly on beat 9.
- start held high continuously: loads accepted at S and S+13 only. weights_valid drops at S+14 and rises again at S+26.
- Misaligned core: the model's index is preset to 3, so weight_load_done fires on beat 6. Required: done and err at S+12, weights_valid stays 0. Core model index initialised to 0 instead: clean.
- Wrap: base_addr = 2^ADDR_W-4 -> mem_raddr sequence 1020,1021,1022,1023,0,1,2,3,4.
- Async reset: assert rst_n=0 at S+6 (mid-stream). Required: weight_load, busy, mem_ren are 0 immediately without waiting for a clock; no done pulse. After release, a new start completes a clean load.
